// File: rtl/ftdi_fifo_emulator_if.sv
// Bundle of the controller-side FIFO bus and the host-side streaming ports of
// the FTDI FIFO emulator. The slave view is the emulator; the master view is
// whatever drives it (FIFO controller plus host).
interface ftdi_fifo_emulator_if #(
  parameter int AW = 4
);
  // Controller (FTDI-style) side, strobes active-low
  logic          oe;
  logic          rd;
  logic          wr;
  logic          rxf;
  logic          txe;
  logic [7:0]    d_out;
  logic          d_oe;
  logic [7:0]    d_in;
  // Host side, valid/ready
  logic [7:0]    h_rx_data;
  logic          h_rx_valid;
  logic          h_rx_ready;
  logic [7:0]    h_tx_data;
  logic          h_tx_valid;
  logic          h_tx_ready;
  // Status
  logic [AW:0]   rx_count;
  logic [AW:0]   tx_count;
  logic          rx_underrun;
  logic          tx_overflow;

  modport slave (
    input  oe, rd, wr, d_in, h_rx_data, h_rx_valid, h_tx_ready,
    output rxf, txe, d_out, d_oe, h_rx_ready, h_tx_data, h_tx_valid,
           rx_count, tx_count, rx_underrun, tx_overflow
  );

  modport master (
    output oe, rd, wr, d_in, h_rx_data, h_rx_valid, h_tx_ready,
    input  rxf, txe, d_out, d_oe, h_rx_ready, h_tx_data, h_tx_valid,
           rx_count, tx_count, rx_underrun, tx_overflow
  );
endinterface

// File: rtl/ftdi_fifo_emulator.sv
// FTDI FIFO emulator: an RX FIFO filled by the host and drained by the
// controller (rd strobe, first-word-fall-through on d_out), and a TX FIFO
// filled by the controller (wr strobe) and drained by the host. Both paths are
// fully independent; rxf/txe are registered from next-state occupancy so they
// track the edge that changed the count with no extra cycle.
module ftdi_fifo_emulator #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  ftdi_fifo_emulator_if.slave   bus
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  // Storage
  logic [7:0]    rx_mem [DEPTH];
  logic [7:0]    tx_mem [DEPTH];

  // RX path state
  logic [AW-1:0] rx_wp_q, rx_wp_d;
  logic [AW-1:0] rx_rp_q, rx_rp_d;
  logic [AW:0]   rx_count_q, rx_count_d;
  logic          rxf_q, rxf_d;
  logic          rx_underrun_q, rx_underrun_d;

  // TX path state
  logic [AW-1:0] tx_wp_q, tx_wp_d;
  logic [AW-1:0] tx_rp_q, tx_rp_d;
  logic [AW:0]   tx_count_q, tx_count_d;
  logic          txe_q, txe_d;
  logic          tx_overflow_q, tx_overflow_d;

  // Per-edge transfer decisions
  logic          rx_push, rx_pop;
  logic          tx_push, tx_pop;
  logic          rx_ready, tx_valid;

  // RX next-state: host push when not full, controller pop when not empty
  always_comb begin
    rx_ready      = (rx_count_q != FULL);
    rx_push       = bus.h_rx_valid && rx_ready;
    rx_pop        = !bus.rd && (rx_count_q != '0);
    rx_wp_d       = rx_wp_q;
    rx_rp_d       = rx_rp_q;
    rx_count_d    = rx_count_q;
    rx_underrun_d = rx_underrun_q || (!bus.rd && (rx_count_q == '0));
    // Pointers are AW bits wide and DEPTH is 2**AW, so +1 wraps naturally.
    if (rx_push) rx_wp_d = rx_wp_q + AW'(1);
    if (rx_pop)  rx_rp_d = rx_rp_q + AW'(1);
    unique case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + (AW+1)'(1);
      2'b01:   rx_count_d = rx_count_q - (AW+1)'(1);
      default: rx_count_d = rx_count_q;
    endcase
    rxf_d = (rx_count_d == '0);
  end

  // TX next-state: controller write when not full, host drain when not empty
  always_comb begin
    tx_valid      = (tx_count_q != '0);
    tx_push       = !bus.wr && (tx_count_q != FULL);
    tx_pop        = tx_valid && bus.h_tx_ready;
    tx_wp_d       = tx_wp_q;
    tx_rp_d       = tx_rp_q;
    tx_count_d    = tx_count_q;
    tx_overflow_d = tx_overflow_q || (!bus.wr && (tx_count_q == FULL));
    if (tx_push) tx_wp_d = tx_wp_q + AW'(1);
    if (tx_pop)  tx_rp_d = tx_rp_q + AW'(1);
    unique case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + (AW+1)'(1);
      2'b01:   tx_count_d = tx_count_q - (AW+1)'(1);
      default: tx_count_d = tx_count_q;
    endcase
    txe_d = (tx_count_d == FULL);
  end

  // Control registers, asynchronously cleared; rxf idles high (RX empty)
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_wp_q       <= '0;
      rx_rp_q       <= '0;
      rx_count_q    <= '0;
      rxf_q         <= 1'b1;
      rx_underrun_q <= 1'b0;
      tx_wp_q       <= '0;
      tx_rp_q       <= '0;
      tx_count_q    <= '0;
      txe_q         <= 1'b0;
      tx_overflow_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values computed by the always_comb blocks.
      rx_wp_q       <= rx_wp_d;
      rx_rp_q       <= rx_rp_d;
      rx_count_q    <= rx_count_d;
      rxf_q         <= rxf_d;
      rx_underrun_q <= rx_underrun_d;
      tx_wp_q       <= tx_wp_d;
      tx_rp_q       <= tx_rp_d;
      tx_count_q    <= tx_count_d;
      txe_q         <= txe_d;
      tx_overflow_q <= tx_overflow_d;
    end
  end

  // FIFO storage writes
  // NOTE: the data arrays are deliberately not reset; emptiness is tracked by
  // the pointers/counts, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp_q] <= bus.h_rx_data;
    if (tx_push) tx_mem[tx_wp_q] <= bus.d_in;
  end

  // Outputs: heads are read combinationally (first-word-fall-through)
  assign bus.d_out       = rx_mem[rx_rp_q];
  assign bus.d_oe        = !bus.oe;
  assign bus.rxf         = rxf_q;
  assign bus.h_rx_ready  = rx_ready;
  assign bus.rx_count    = rx_count_q;
  assign bus.rx_underrun = rx_underrun_q;
  assign bus.h_tx_data   = tx_mem[tx_rp_q];
  assign bus.h_tx_valid  = tx_valid;
  assign bus.txe         = txe_q;
  assign bus.tx_count    = tx_count_q;
  assign bus.tx_overflow = tx_overflow_q;

endmodule

// File: tb/tb_ftdi_fifo_emulator.sv
// Self-checking bench for ftdi_fifo_emulator: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_ftdi_fifo_emulator;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk;
  logic n_rst;

  ftdi_fifo_emulator_if #(.AW(AW)) bus ();

  ftdi_fifo_emulator #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: byte queues plus sticky flags
  logic [7:0] rx_q [$];
  logic [7:0] tx_q [$];
  logic       m_under;
  logic       m_over;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs against the
  // model's pre-edge state, clock, advance the model, check registered state.
  task automatic step(input logic oe_n, input logic rd_n, input logic wr_n,
                      input logic rx_v, input logic [7:0] rx_d,
                      input logic [7:0] din, input logic tx_r);
    bit rx_push, rx_pop, tx_push, tx_pop;
    bus.oe = oe_n; bus.rd = rd_n; bus.wr = wr_n;
    bus.h_rx_valid = rx_v; bus.h_rx_data = rx_d;
    bus.d_in = din; bus.h_tx_ready = tx_r;
    #1;
    check("h_rx_ready", 32'(bus.h_rx_ready), 32'(rx_q.size() != DEPTH));
    check("h_tx_valid", 32'(bus.h_tx_valid), 32'(tx_q.size() != 0));
    check("d_oe",       32'(bus.d_oe),       32'(!oe_n));
    if (rx_q.size() > 0) check("d_out",     32'(bus.d_out),     32'(rx_q[0]));
    if (tx_q.size() > 0) check("h_tx_data", 32'(bus.h_tx_data), 32'(tx_q[0]));

    rx_push = rx_v && (rx_q.size() < DEPTH);
    rx_pop  = !rd_n && (rx_q.size() > 0);
    tx_push = !wr_n && (tx_q.size() < DEPTH);
    tx_pop  = tx_r && (tx_q.size() > 0);
    if (!rd_n && rx_q.size() == 0)     m_under = 1'b1;
    if (!wr_n && tx_q.size() == DEPTH) m_over  = 1'b1;

    @(posedge clk);
    #1;
    if (rx_pop)  void'(rx_q.pop_front());
    if (rx_push) rx_q.push_back(rx_d);
    if (tx_pop)  void'(tx_q.pop_front());
    if (tx_push) tx_q.push_back(din);

    check("rx_count",    32'(bus.rx_count),    32'(rx_q.size()));
    check("tx_count",    32'(bus.tx_count),    32'(tx_q.size()));
    check("rxf",         32'(bus.rxf),         32'(rx_q.size() == 0));
    check("txe",         32'(bus.txe),         32'(tx_q.size() == DEPTH));
    check("rx_underrun", 32'(bus.rx_underrun), 32'(m_under));
    check("tx_overflow", 32'(bus.tx_overflow), 32'(m_over));
    if (rx_q.size() > 0) check("d_out_post", 32'(bus.d_out), 32'(rx_q[0]));
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  // Mid-cycle asynchronous reset; outputs must clear before any clock edge.
  task automatic pulse_reset();
    bus.oe = 1'b1; bus.rd = 1'b1; bus.wr = 1'b1;
    bus.h_rx_valid = 1'b0; bus.h_tx_ready = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    check("rst_rx_count",    32'(bus.rx_count),    32'd0);
    check("rst_tx_count",    32'(bus.tx_count),    32'd0);
    check("rst_rxf",         32'(bus.rxf),         32'd1);
    check("rst_txe",         32'(bus.txe),         32'd0);
    check("rst_rx_underrun", 32'(bus.rx_underrun), 32'd0);
    check("rst_tx_overflow", 32'(bus.tx_overflow), 32'd0);
    check("rst_h_rx_ready",  32'(bus.h_rx_ready),  32'd1);
    check("rst_h_tx_valid",  32'(bus.h_tx_valid),  32'd0);
    @(posedge clk);
    #1 n_rst = 1'b1;
    rx_q.delete();
    tx_q.delete();
    m_under = 1'b0;
    m_over  = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0;
    bus.oe = 1'b1; bus.rd = 1'b1; bus.wr = 1'b1;
    bus.h_rx_valid = 1'b0; bus.h_rx_data = 8'h00;
    bus.d_in = 8'h00; bus.h_tx_ready = 1'b0;
    m_under = 1'b0;
    m_over  = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;

    // Reset then idle
    idle();
    idle();
    check("idle_rxf", 32'(bus.rxf), 32'd1);
    check("idle_txe", 32'(bus.txe), 32'd0);

    // Host pushes two bytes; controller enables bus then pops twice
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h00, 1'b0);
    check("rx_fwft_head", 32'(bus.d_out), 32'hA5);
    check("rx_fwft_rxf",  32'(bus.rxf),   32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    check("first_byte", 32'(bus.d_out), 32'hA5);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    check("second_byte", 32'(bus.d_out), 32'h3C);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    check("rxf_after_pops", 32'(bus.rxf),         32'd1);
    check("no_underrun",    32'(bus.rx_underrun), 32'd0);
    idle();

    // Controller fills TX, overflows once, then host drains in order
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'(i), 1'b0);
    check("txe_full", 32'(bus.txe), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0);
    check("tx_overflow_set", 32'(bus.tx_overflow), 32'd1);
    check("tx_count_full",   32'(bus.tx_count),    32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      check("tx_drain_order", 32'(bus.h_tx_data), 32'(i));
      step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    end
    check("tx_drained", 32'(bus.h_tx_valid), 32'd0);

    // Pop with RX empty sets a sticky underrun
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    check("underrun_set", 32'(bus.rx_underrun), 32'd1);
    repeat (3) idle();
    check("underrun_sticky", 32'(bus.rx_underrun), 32'd1);

    // Load 5 RX and 7 TX bytes, then reset asynchronously mid-transfer
    for (int i = 0; i < 7; i++)
      step(1'b1, 1'b1, 1'b0, (i < 5), 8'(8'h50 + i), 8'(8'h70 + i), 1'b0);
    check("pre_rst_rx", 32'(bus.rx_count), 32'd5);
    check("pre_rst_tx", 32'(bus.tx_count), 32'd7);
    pulse_reset();
    idle();

    // Fill RX, then pop and push on the same edge while full
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 1'b1, 1'b1, 1'b1, 8'(8'h10 + i), 8'h00, 1'b0);
    check("rx_full_ready", 32'(bus.h_rx_ready), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 8'h00, 1'b0);
    check("full_pop_push", 32'(bus.rx_count), 32'(DEPTH - 1));
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h88, 8'h00, 1'b0);
    check("refill", 32'(bus.rx_count), 32'(DEPTH));
    while (rx_q.size() > 0)
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    // Stream 40 bytes through RX to exercise pointer wrap
    for (int i = 0; i < 40; i++)
      step(1'b0, !((rx_q.size() > 0) && (i % 3 != 0)), 1'b1, 1'b1,
           8'(8'h40 + i), 8'h00, 1'b0);
    while (rx_q.size() > 0)
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    check("stream_underrun", 32'(bus.rx_underrun), 32'd0);

    // Random traffic on both paths, with an occasional reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) pulse_reset();
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 1),
           8'($urandom),
           8'($urandom),
           ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
